ag_ps2_rx: RTL and testbench
============================

Name: ag_ps2_rx

Overview:
- PS/2 keyboard frame receiver between the filtered PS/2 lines (signal_filter outputs) and the keyboard decoder.
- Samples ps2 clock/data in the system clock domain and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Checks each frame and pushes good scan codes into a small FIFO so bursts (E0/F0 prefixes) are not lost while the decoder is busy.
- The decoder pops codes with a one-cycle ack.

Parameters:
- TIMEOUT, 2000: clk cycles without a ps2_clk falling edge before an in-progress frame is aborted (2 ms at 1 MHz).
- DEPTH, 4: FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, the 1 MHz domain; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  filtered PS/2 clock, already synchronous to clk.
- ps2_data  in  1  filtered PS/2 data, already synchronous to clk.
- rx_data  out  8  scan code at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ack  in  1  pop head this cycle; ignored when empty.
- parity_err  out  1  one-cycle pulse: frame rejected on parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  sticky: good frame dropped because FIFO full; cleared by rx_ack.
- busy  out  1  receiver not in IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, bit/timeout counters 0, FIFO empty, rx_valid=0, rx_data=0, all flags 0. Reset mid-frame discards the partial frame.
- Edge detect: ps2_clk_q registered each clk; fall = ps2_clk_q & ~ps2_clk; data sampled from ps2_data on the cycle fall=1.
- FSM:
  - IDLE: on fall with data=0 go to DATA, bitcnt=0. Fall with data=1 is a glitch start; stay IDLE with no error.
  - DATA: on fall shift data into shreg[7] (right shift, LSB first), bitcnt++. After the 8th bit go to PARITY.
  - PARITY: on fall store par=data, go to STOP.
  - STOP: on fall, if data=0, pulse frame_err. Else if ^{shreg,par} != 1, pulse parity_err. Else push shreg. Then go to IDLE.
  - Parity error takes priority only when the stop bit is good.
- Timeout: counter cleared on every fall and in IDLE, increments in other states. On reaching TIMEOUT-1 go to IDLE and pulse frame_err. A fall in the same cycle is ignored.
- Push latency: code visible on rx_data/rx_valid the cycle after the stop-bit fall cycle.
- FIFO:
  - Circular buffer, wr/rd pointers of log2(DEPTH) bits plus count 0..DEPTH. Pointers wrap naturally.
  - rx_data = mem[rd_ptr] (combinational read of the registered array).
  - Pop when rx_ack & rx_valid.
  - Push when full with no pop: data dropped, overflow<=1.
  - Push when full with simultaneous pop: push accepted, count unchanged, no overflow.
  - Push and pop when not full: count unchanged.
  - rx_ack sets overflow<=0 (same cycle as a new overflow: set wins).
- Errors never modify the FIFO.
- busy = (state != IDLE).

Decomposition:
- Shared package/include ag_ps2_defs: FSM state encodings (IDLE=0, DATA=1, PARITY=2, STOP=3), frame length constant 11, default TIMEOUT.
- One sub-module ag_ps2_fifo (parameter DEPTH, W=8):
  - Inputs: clk, reset_n, push, din, pop.
  - Outputs: dout, empty, full.
- Top contains edge detect, FSM, timeout counter and flags.

Test Plan:
- Frame 0x1C, parity 0, stop 1, 80 µs PS/2 period: rx_valid rises the cycle after the stop fall, rx_data=0x1C; no error pulses. rx_ack then gives rx_valid=0.
- Frame 0xF0, parity 1: rx_data=0xF0. Same frame with parity 0: parity_err pulses once, rx_valid stays 0.
- Frame 0x1C, parity 0, stop bit 0: frame_err pulse, FIFO unchanged, next valid frame 0x5A accepted.
- Start plus 5 data bits, then ps2_clk held high: frame_err exactly TIMEOUT cycles after the last fall, busy=0. A following 0x12 frame is received correctly.
- Five frames 0x01..0x05, no ack, DEPTH=4: overflow=1. Acks pop 0x01,0x02,0x03,0x04 in order, then rx_valid=0. overflow clears on the first ack. 5th frame pushed in the same cycle as an ack when full: accepted, no overflow.
- reset_n pulsed low mid-DATA with FIFO holding 2 codes: rx_valid=0, busy=0 immediately. After release, a full 0x76 frame is received as the sole entry.

Source files
------------

// File: rtl/ag_ps2_defs.sv
// Shared definitions for the PS/2 frame receiver: FSM encodings, frame shape
// and the default inactivity timeout.
package ag_ps2_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // 2 ms at the 1 MHz system clock
    localparam int DEF_TIMEOUT = 2000;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ag_ps2_rx_if.sv
// Decoder-facing side of the PS/2 receiver.
//
// Handshake: rx_valid is high while a scan code sits at the FIFO head and
// rx_data holds it; the consumer raises rx_ack for one cycle to pop it.
// A pop happens only on a cycle where rx_valid & rx_ack are both high;
// rx_ack with rx_valid low is ignored by the FIFO but still clears overflow.
// parity_err / frame_err are single-cycle pulses, overflow is sticky.
interface ag_ps2_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overflow, busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overflow, busy,
        output rx_ack
    );
endinterface

// File: rtl/ag_ps2_rx_fifo.sv
// Small circular FIFO holding received scan codes until the decoder pops them.
// A push into a full FIFO is accepted only if a pop frees a slot in the same
// cycle; otherwise it is dropped and the caller decides what to flag.
module ag_ps2_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ag_ps2_rx.sv
// PS/2 keyboard frame receiver: detects falling edges of the filtered PS/2
// clock, deserialises start/8 data/parity/stop, validates the frame and
// queues good scan codes for the decoder.
module ag_ps2_rx
    import ag_ps2_defs::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ag_ps2_rx_if.master     rx,
    output rx_state_e       state_dbg
);
    localparam int DATA_BITS = FRAME_BITS - 3;
    localparam int TW        = $clog2(TIMEOUT + 1);

    rx_state_e     state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt;
    logic          ps2_clk_q;
    logic          fall;
    logic          timeout;
    logic          push;
    logic          perr_c;
    logic          ferr_c;
    logic          overflow_q;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop_now;

    // Previous PS/2 clock level; idles high so reset never fakes a fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_q <= 1'b1;
        end else begin
            ps2_clk_q <= ps2_clk;
        end
    end

    assign fall    = ps2_clk_q & ~ps2_clk;
    assign timeout = (state != ST_IDLE) && (tcnt == TW'(TIMEOUT - 1));

    // Inactivity counter: restarts on each clock fall and stays at zero in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (state == ST_IDLE || fall || timeout) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            par    <= par_n;
        end
    end

    // Next-state decode; a timeout wins over any fall seen in the same cycle.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        push     = 1'b0;
        perr_c   = 1'b0;
        ferr_c   = 1'b0;
        if (timeout) begin
            state_n = ST_IDLE;
            ferr_c  = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    // A high data line here is a glitch, not a start bit.
                    if (!ps2_data) begin
                        state_n  = ST_DATA;
                        bitcnt_n = '0;
                    end
                end
                ST_DATA: begin
                    shreg_n  = {ps2_data, shreg[7:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'(DATA_BITS - 1)) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_n   = ps2_data;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    // A bad stop bit masks any parity problem.
                    if (!ps2_data) begin
                        ferr_c = 1'b1;
                    end else if (!parity_ok(shreg, par)) begin
                        perr_c = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    ag_ps2_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (shreg),
        .pop     (rx.rx_ack),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign pop_now = rx.rx_ack & ~fifo_empty;

    // Sticky overflow: set when a good code is dropped, cleared by any ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop_now) begin
            overflow_q <= 1'b1;
        end else if (rx.rx_ack) begin
            overflow_q <= 1'b0;
        end
    end

    assign rx.rx_data    = fifo_dout;
    assign rx.rx_valid   = ~fifo_empty;
    assign rx.parity_err = perr_c;
    assign rx.frame_err  = ferr_c;
    assign rx.overflow   = overflow_q;
    assign rx.busy       = (state != ST_IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_ag_ps2_rx.sv
// Bench for ag_ps2_rx: drives PS/2 frames at an 80-cycle bit period and
// checks popped codes against an expected queue, plus error/overflow flags.
`timescale 1ns/1ps
module tb_ag_ps2_rx;
    import ag_ps2_defs::*;

    localparam int TIMEOUT = 2000;
    localparam int DEPTH   = 4;
    localparam int HALF    = 40;

    logic      clk      = 1'b0;
    logic      reset_n  = 1'b0;
    logic      ps2_clk  = 1'b1;
    logic      ps2_data = 1'b1;
    rx_state_e state_dbg;

    ag_ps2_rx_if rx_if ();

    ag_ps2_rx #(
        .TIMEOUT (TIMEOUT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx        (rx_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #500 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pe_cnt = 0;
    int   fe_cnt = 0;
    int   fe_cyc = -1;
    int   rise_cyc = -1;
    int   last_fall = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling clk edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_if.parity_err) pe_cnt++;
            if (rx_if.frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (rx_if.rx_valid && !prev_valid) rise_cyc = cyc;
            if (rx_if.rx_ack && rx_if.rx_valid) begin
                if (exp_q.size() == 0) check("pop_extra", 32'(exp_q.size()), 1);
                else                   check("pop_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = rx_if.rx_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input logic ack_on_fall = 1'b0);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        if (ack_on_fall) rx_if.rx_ack = 1'b1;
        tick(1);
        rx_if.rx_ack = 1'b0;
        tick(HALF - 1);
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic expect_ok, input logic ack_on_stop = 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        if (expect_ok) exp_q.push_back(d);
        ps2_bit(stop, ack_on_stop);
    endtask

    task automatic do_ack();
        rx_if.rx_ack = 1'b1;
        tick(1);
        rx_if.rx_ack = 1'b0;
        tick(1);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // ---------------- stimulus ----------------
    int pe0, fe0, f0;

    initial begin
        rx_if.rx_ack = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_valid", 32'(rx_if.rx_valid), 0);
        check("rst_data",  32'(rx_if.rx_data), 0);
        check("rst_busy",  32'(rx_if.busy), 0);
        check("rst_ovf",   32'(rx_if.overflow), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1;
        tick(2);

        // Good 0x1C frame: latency, data, no error pulses, ack empties.
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        check("lat_1c",   32'(rise_cyc), 32'(last_fall + 1));
        check("data_1c",  32'(rx_if.rx_data), 32'h1C);
        check("perr_1c",  32'(pe_cnt - pe0), 0);
        check("ferr_1c",  32'(fe_cnt - fe0), 0);
        do_ack();
        check("empty_1c", 32'(rx_if.rx_valid), 0);

        // 0xF0 with good parity, then with bad parity.
        send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
        check("data_f0", 32'(rx_if.rx_data), 32'hF0);
        do_ack();
        pe0 = pe_cnt;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("perr_f0",  32'(pe_cnt - pe0), 1);
        check("valid_pe", 32'(rx_if.rx_valid), 0);

        // Bad stop bit, then a good 0x5A.
        fe0 = fe_cnt; pe0 = pe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("ferr_stop",  32'(fe_cnt - fe0), 1);
        check("perr_stop",  32'(pe_cnt - pe0), 0);
        check("valid_stop", 32'(rx_if.rx_valid), 0);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b1);
        check("valid_5a", 32'(rx_if.rx_valid), 1);
        do_ack();

        // Truncated frame: start + 5 data bits, then the clock stays high.
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1));
        f0 = last_fall;
        check("busy_trunc", 32'(rx_if.busy), 1);
        tick(TIMEOUT + 50);
        check("ferr_to",   32'(fe_cnt - fe0), 1);
        check("to_delay",  32'(fe_cyc - f0), TIMEOUT);
        check("busy_to",   32'(rx_if.busy), 0);
        check("state_to",  32'(state_dbg), 32'(ST_IDLE));
        send_frame(8'h12, odd_par(8'h12), 1'b1, 1'b1);
        check("data_12", 32'(rx_if.rx_data), 32'h12);
        do_ack();

        // Overflow: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), odd_par(8'(i)), 1'b1, (i <= DEPTH));
        end
        check("ovf_set", 32'(rx_if.overflow), 1);
        do_ack();
        check("ovf_clr", 32'(rx_if.overflow), 0);
        for (int i = 0; i < DEPTH - 1; i++) do_ack();
        check("valid_drain", 32'(rx_if.rx_valid), 0);

        // Full FIFO with an ack landing on the stop-bit fall: push accepted.
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h11 + 8'(i), odd_par(8'h11 + 8'(i)), 1'b1, 1'b1);
        end
        send_frame(8'h15, odd_par(8'h15), 1'b1, 1'b1, 1'b1);
        check("ovf_simul", 32'(rx_if.overflow), 0);
        for (int i = 0; i < DEPTH; i++) do_ack();
        check("valid_simul", 32'(rx_if.rx_valid), 0);

        // Reset mid-frame with two codes queued.
        send_frame(8'h21, odd_par(8'h21), 1'b1, 1'b1);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rx_if.rx_valid), 0);
        check("rst_mid_busy",  32'(rx_if.busy), 0);
        exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(2);
        send_frame(8'h76, odd_par(8'h76), 1'b1, 1'b1);
        check("data_76", 32'(rx_if.rx_data), 32'h76);
        do_ack();
        check("valid_76", 32'(rx_if.rx_valid), 0);
        check("q_left", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
